// File: rtl/encoder_step_cmd_if.sv
// ============================================================================
// encoder_step_cmd_if : encoder inputs, limit switches and driver command bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface encoder_step_cmd_if;
  logic              enc_a;
  logic              enc_b;
  logic              limSUP;
  logic              limINF;
  logic [1:0]        enable;
  logic              direccion;
  logic signed [4:0] pending;
  logic              busy;

  modport master (
    output enc_a, enc_b, limSUP, limINF,
    input  enable, direccion, pending, busy
  );

  modport slave (
    input  enc_a, enc_b, limSUP, limINF,
    output enable, direccion, pending, busy
  );
endinterface

`default_nettype wire

// File: rtl/encoder_step_cmd.sv
// ============================================================================
// encoder_step_cmd : x1 quadrature decode into a saturating move queue, issued
// one move at a time as a 1-clk start pulse plus direction, paced by a timer.
// Optional debounce filter on both channels: define ENC_DEBOUNCE_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module encoder_step_cmd #(
  parameter int MOVE_TICKS = 1_650_000,
  parameter int PEND_MAX   = 15,
  parameter int DEB_CYCLES = 50_000
) (
  input  logic               clk,
  input  logic               rst,
  encoder_step_cmd_if.slave  enc_bus
);

  localparam int                c_tw         = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam logic [c_tw-1:0]   c_timer_load = c_tw'(MOVE_TICKS - 1);
  localparam logic signed [5:0] c_pmax       = 6'(PEND_MAX);
  localparam logic signed [5:0] c_pmin       = -c_pmax;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_MOVE  = 2'd2
  } state_t;

  // Channel vectors are packed as {B, A}; synchronizers intentionally carry no reset.
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] w_enc;

  always_ff @(posedge clk) begin
    r_s1 <= {enc_bus.enc_b, enc_bus.enc_a};
    r_s2 <= r_s1;
  end

`ifdef ENC_DEBOUNCE_EN
  localparam int c_dw = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  for (genvar ch = 0; ch < 2; ch++) begin : g_deb
    logic            r_filt;
    logic [c_dw-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_filt <= r_s2[ch];
        r_cnt  <= '0;
      end else if (r_s2[ch] == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt == c_dw'(DEB_CYCLES - 1)) begin
        r_filt <= r_s2[ch];
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + c_dw'(1);
      end
    end

    assign w_enc[ch] = r_filt;
  end
`else
  // Unfiltered build: the decoder sees the synchronizer outputs directly.
  if (DEB_CYCLES >= 0) begin : g_no_deb
    assign w_enc = r_s2;
  end
`endif

  // Previous-A also loads during reset so that releasing reset never looks like an edge.
  logic r_a_prev;

  always_ff @(posedge clk) begin
    r_a_prev <= w_enc[0];
  end

  logic              w_rise;
  logic signed [5:0] w_enc_delta;

  assign w_rise      = w_enc[0] & ~r_a_prev;
  assign w_enc_delta = !w_rise ? 6'sd0 : (w_enc[1] ? -6'sd1 : 6'sd1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_dir;
  logic              w_dir_nxt;
  logic [c_tw-1:0]   r_timer;
  logic [c_tw-1:0]   w_timer_nxt;
  logic signed [4:0] r_pend;
  logic signed [4:0] w_pend_nxt;
  logic signed [5:0] w_issue_delta;
  logic signed [5:0] w_sum;
  logic              w_discard;
  logic [1:0]        w_enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_timer <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_timer <= w_timer_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_timer_nxt   = r_timer;
    w_issue_delta = 6'sd0;
    w_discard     = 1'b0;
    w_enable      = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (r_pend > 0) begin
          if (!enc_bus.limSUP) begin
            w_dir_nxt   = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_discard   = 1'b1;
          end
        end else if (r_pend < 0) begin
          if (!enc_bus.limINF) begin
            w_dir_nxt   = 1'b0;
            w_state_nxt = S_ISSUE;
          end else begin
            w_discard   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        w_enable      = 2'b01;
        w_timer_nxt   = c_timer_load;
        w_state_nxt   = S_MOVE;
        if (r_pend > 0) begin
          w_issue_delta = -6'sd1;
        end else if (r_pend < 0) begin
          w_issue_delta = 6'sd1;
        end
      end
      S_MOVE: begin
        if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - c_tw'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Six bits hold the worst-case unsaturated sum of +/-PEND_MAX +/-1 +/-1.
    w_sum = {r_pend[4], r_pend} + w_enc_delta + w_issue_delta;
    if (w_discard) begin
      w_pend_nxt = '0;
    end else if (w_sum > c_pmax) begin
      w_pend_nxt = c_pmax[4:0];
    end else if (w_sum < c_pmin) begin
      w_pend_nxt = c_pmin[4:0];
    end else begin
      w_pend_nxt = w_sum[4:0];
    end
  end

  assign enc_bus.enable    = w_enable;
  assign enc_bus.direccion = r_dir;
  assign enc_bus.pending   = r_pend;
  assign enc_bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
